// File: rtl/fft_pkg.sv
// fft_pkg: complex sample layout, widths and index helpers shared by the FFT datapath.
package fft_pkg;

    localparam int CPLX_W = 32;
    localparam int HALF_W = 16;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_DRAIN
    } rd_state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned nbits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < nbits) r[5'(i)] = value[5'(nbits - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_mag_approx.sv
// cplx_mag_approx: combinational alpha-max-plus-beta-min magnitude, mag = max + min/4 + min/8,
// with a saturating absolute value so the most negative input maps to the largest positive one.
module cplx_mag_approx
    import fft_pkg::*;
#(
    parameter int HW = HALF_W
) (
    input  logic signed [HW-1:0] i_re,
    input  logic signed [HW-1:0] i_im,
    output logic        [HW-1:0] o_mag
);

    logic [HW-2:0] w_neg_re;
    logic [HW-2:0] w_neg_im;
    logic [HW-2:0] w_abs_re;
    logic [HW-2:0] w_abs_im;
    logic [HW-2:0] w_max;
    logic [HW-2:0] w_min;

    // For any negative value other than the minimum, -x fits in HW-1 bits.
    assign w_neg_re = ~i_re[HW-2:0] + (HW-1)'(1);
    assign w_neg_im = ~i_im[HW-2:0] + (HW-1)'(1);

    always_comb begin
        w_abs_re = i_re[HW-2:0];
        if (i_re[HW-1]) w_abs_re = (i_re[HW-2:0] == '0) ? '1 : w_neg_re;
        w_abs_im = i_im[HW-2:0];
        if (i_im[HW-1]) w_abs_im = (i_im[HW-2:0] == '0) ? '1 : w_neg_im;
        if (w_abs_re >= w_abs_im) begin
            w_max = w_abs_re;
            w_min = w_abs_im;
        end else begin
            w_max = w_abs_im;
            w_min = w_abs_re;
        end
    end

    // Peak result (max = min = 2^(HW-1)-1) stays below 2^HW, so an HW-bit sum is exact.
    assign o_mag = HW'(w_max) + HW'(w_min >> 2) + HW'(w_min >> 3);

endmodule

// File: rtl/fft_bin_reader.sv
// fft_bin_reader: walks the FFT result RAM after a frame and streams one magnitude per bin.
// Optional: FFT_READER_DC_BLANK_EN forces the magnitude of bin 0 to zero.
module fft_bin_reader
    import fft_pkg::*;
#(
    parameter int WIDTH         = CPLX_W,
    parameter int N_LOG2        = 8,
    parameter int HALF_SPECTRUM = 1,
    parameter int BIT_REVERSE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 rd_en,
    output logic [N_LOG2-1:0]    rd_addr,
    input  logic [WIDTH-1:0]     rd_data,
    output logic                 bin_valid,
    input  logic                 bin_ready,
    output logic [N_LOG2-1:0]    bin_idx,
    output logic [WIDTH/2-1:0]   bin_mag,
    output logic                 bin_last,
    output logic                 busy,
    output logic                 done
);

    localparam int HW = WIDTH / 2;
    localparam logic [N_LOG2-1:0] K_LAST =
        N_LOG2'((1 << (N_LOG2 - ((HALF_SPECTRUM != 0) ? 1 : 0))) - 1);

    rd_state_t r_state;
    rd_state_t w_state_nxt;

    logic [N_LOG2-1:0] r_k;
    logic              r_inflight;
    logic [N_LOG2-1:0] r_ret_idx;
    logic              r_ret_last;
    logic              r_done;

    logic [N_LOG2-1:0] r_f_idx  [2];
    logic [HW-1:0]     r_f_mag  [2];
    logic              r_f_last [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_head_vld;
    logic              w_credit_ok;
    logic [2:0]        w_occ;
    logic [N_LOG2-1:0] w_addr;
    logic [HW-1:0]     w_mag;
    logic [HW-1:0]     w_push_mag;

    cplx_mag_approx #(
        .HW (HW)
    ) u_mag (
        .i_re  (rd_data[WIDTH-1:HW]),
        .i_im  (rd_data[HW-1:0]),
        .o_mag (w_mag)
    );

`ifdef FFT_READER_DC_BLANK_EN
    assign w_push_mag = (r_ret_idx == '0) ? '0 : w_mag;
`else
    assign w_push_mag = w_mag;
`endif

    assign w_head_vld = (r_count != 2'd0);
    assign w_push     = r_inflight;
    assign w_pop      = bin_valid && bin_ready;
    assign w_occ      = 3'(r_count) + 3'(r_inflight);
    // A beat leaving this cycle frees its slot before the new read can land, which keeps one bin per cycle.
    assign w_credit_ok = w_pop ? (w_occ < 3'd3) : (w_occ < 3'd2);
    assign w_addr     = (BIT_REVERSE != 0) ? N_LOG2'(bitrev(32'(r_k), N_LOG2)) : r_k;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (start) w_state_nxt = RD_ISSUE;
            end
            RD_ISSUE: begin
                w_issue = w_credit_ok;
                if (w_credit_ok && (r_k == K_LAST)) w_state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (w_pop && r_f_last[r_rptr]) w_state_nxt = RD_IDLE;
            end
            default: w_state_nxt = RD_IDLE;
        endcase
        if (rst) w_issue = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RD_IDLE;
            r_k        <= '0;
            r_inflight <= 1'b0;
            r_ret_idx  <= '0;
            r_ret_last <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            r_done     <= (r_state == RD_DRAIN) && w_pop && r_f_last[r_rptr];
            if ((r_state == RD_IDLE) && start) begin
                r_k <= '0;
            end else if (w_issue) begin
                r_k <= r_k + N_LOG2'(1);
            end
            if (w_issue) begin
                r_ret_idx  <= r_k;
                r_ret_last <= (r_k == K_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_f_idx[i]  <= '0;
                r_f_mag[i]  <= '0;
                r_f_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_f_idx[r_wptr]  <= r_ret_idx;
                r_f_mag[r_wptr]  <= w_push_mag;
                r_f_last[r_wptr] <= r_ret_last;
                r_wptr           <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rd_en     = w_issue;
    assign rd_addr   = rst ? '0 : w_addr;
    assign bin_valid = !rst && w_head_vld;
    assign bin_idx   = rst ? '0 : r_f_idx[r_rptr];
    assign bin_mag   = rst ? '0 : r_f_mag[r_rptr];
    assign bin_last  = !rst && r_f_last[r_rptr];
    assign busy      = !rst && (r_state != RD_IDLE);
    assign done      = !rst && r_done;

endmodule

// File: tb/tb_fft_bin_reader.sv
// tb_fft_bin_reader: directed checks of fft_bin_reader with an 8-point, half-spectrum, bit-reversed RAM.
module tb_fft_bin_reader;
    import fft_pkg::*;

    localparam int NL = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          bin_ready = 1'b1;
    logic          rd_en;
    logic [NL-1:0] rd_addr;
    logic [31:0]   rd_data   = '0;
    logic          bin_valid;
    logic [NL-1:0] bin_idx;
    logic [15:0]   bin_mag;
    logic          bin_last;
    logic          busy;
    logic          done;

    logic [31:0]   ram      [8];
    logic [15:0]   exp_mag  [4];
    logic [NL-1:0] exp_addr [4];

    int t1_rden  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int t1_valid [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    int t1_idx   [8] = '{0, 0, 0, 1, 2, 3, 0, 0};
    int t1_busy  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int t1_done  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    int n_cmp = 0;
    int n_bad = 0;

    fft_bin_reader #(
        .WIDTH         (32),
        .N_LOG2        (NL),
        .HALF_SPECTRUM (1),
        .BIT_REVERSE   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_idx   (bin_idx),
        .bin_mag   (bin_mag),
        .bin_last  (bin_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM; rd_data keeps its last value when not read.
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_rd_en"}, rd_en, 0);
        check_eq({tag, "_valid"}, bin_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input int lo_a, input int lo_b, input int restart_at);
        int            issued   = 0;
        int            accepted = 0;
        int            dones    = 0;
        int            cyc      = 0;
        logic          held     = 1'b0;
        logic [NL-1:0] h_idx    = '0;
        logic [15:0]   h_mag    = '0;
        logic          h_last   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (dones == 0 && cyc < 40) begin
            cyc++;
            bin_ready = !(cyc == lo_a || cyc == lo_b);
            start     = (cyc == restart_at);
            #1;
            check_eq("outstanding_le2", 32'((issued - accepted) <= 2), 1);
            if (held) begin
                check_eq("hold_valid", bin_valid, 1);
                check_eq("hold_idx", bin_idx, h_idx);
                check_eq("hold_mag", bin_mag, h_mag);
                check_eq("hold_last", bin_last, h_last);
            end
            if (rd_en) begin
                if (issued < 4) check_eq("rd_addr", rd_addr, exp_addr[issued]);
                issued++;
            end
            if (bin_valid && bin_ready) begin
                if (accepted < 4) begin
                    check_eq("beat_idx", bin_idx, accepted);
                    check_eq("beat_mag", bin_mag, exp_mag[accepted]);
                    check_eq("beat_last", bin_last, 32'(accepted == 3));
                end
                accepted++;
            end
            held   = bin_valid && !bin_ready;
            h_idx  = bin_idx;
            h_mag  = bin_mag;
            h_last = bin_last;
            if (done) begin
                dones++;
                check_eq("done_busy", busy, 0);
            end
            @(negedge clk);
        end
        start     = 1'b0;
        bin_ready = 1'b1;
        check_eq("frame_done_seen", dones, 1);
        check_eq("frame_beats", accepted, 4);
        check_eq("frame_reads", issued, 4);
        repeat (3) begin
            #1 check_idle("post_frame");
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 32'hDEAD_BEEF;
        ram[0] = 32'h7FFF_0000;
        ram[4] = 32'h4000_0000;
        ram[2] = 32'hC000_C000;
        ram[6] = 32'h8000_8000;
        exp_mag  = '{16'd32767, 16'd16384, 16'd22528, 16'd45053};
`ifdef FFT_READER_DC_BLANK_EN
        exp_mag[0] = 16'd0;
`endif
        exp_addr = '{3'd0, 3'd4, 3'd2, 3'd6};

        repeat (2) @(negedge clk);
        check_idle("reset");
        check_eq("reset_mag", bin_mag, 0);
        check_eq("reset_last", bin_last, 0);
        rst = 1'b0;
        @(negedge clk);

        // Cycle-exact frame with ready held high.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_eq("t1_rd_en", rd_en, t1_rden[c]);
            if (t1_rden[c] != 0) check_eq("t1_rd_addr", rd_addr, exp_addr[c]);
            check_eq("t1_valid", bin_valid, t1_valid[c]);
            if (t1_valid[c] != 0) begin
                check_eq("t1_idx", bin_idx, t1_idx[c]);
                check_eq("t1_mag", bin_mag, exp_mag[t1_idx[c]]);
                check_eq("t1_last", bin_last, 32'(t1_idx[c] == 3));
            end
            check_eq("t1_busy", busy, t1_busy[c]);
            check_eq("t1_done", done, t1_done[c]);
            @(negedge clk);
        end

        // Backpressure 1,0,0,1 on the beats plus a spurious start mid-frame.
        run_frame(4, 5, 4);

        // Reset during the second beat, then a clean frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("pre_rst_valid", bin_valid, 1);
        check_eq("pre_rst_idx", bin_idx, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle("in_rst");
        check_eq("in_rst_idx", bin_idx, 0);
        check_eq("in_rst_mag", bin_mag, 0);
        check_eq("in_rst_last", bin_last, 0);
        check_eq("in_rst_addr", rd_addr, 0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1 check_idle("after_rst");
        end
        @(negedge clk);
        run_frame(-1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
        $fatal(1);
    end

endmodule
